// File: rtl/button_conditioner.sv
// Turns raw panel buttons into clean clk_1khz events: synchronise, optional
// inversion, debounce, press/release pulses, long-press flag and auto-repeat steps.
module button_conditioner #(
  parameter int                 NUM_BTN          = 3,
  parameter logic [NUM_BTN-1:0] BTN_INVERT       = 3'b100,
  parameter int                 DEBOUNCE_MS      = 20,
  parameter int                 REPEAT_DELAY_MS  = 500,
  parameter int                 REPEAT_PERIOD_MS = 200
) (
  input  logic               clk_1khz,
  input  logic               switch_clr,
  input  logic [NUM_BTN-1:0] btn_raw,
  input  logic [NUM_BTN-1:0] repeat_en,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_step,
  output logic [NUM_BTN-1:0] btn_long
);

  localparam int DB_W   = $clog2(DEBOUNCE_MS + 1);
  localparam int HOLD_W = $clog2(REPEAT_DELAY_MS + 1);
  localparam int PER_W  = $clog2(REPEAT_PERIOD_MS + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HELD = 1'b1;

  logic [NUM_BTN-1:0] sync_meta;
  logic [NUM_BTN-1:0] sync_q;
  logic [NUM_BTN-1:0] s;

  always_ff @(posedge clk_1khz or negedge switch_clr) begin
    if (!switch_clr) begin
      sync_meta <= '0;
      sync_q    <= '0;
    end else begin
      sync_meta <= btn_raw;
      sync_q    <= sync_meta;
    end
  end

  assign s = sync_q ^ BTN_INVERT;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    logic [0:0]        state;
    logic [DB_W-1:0]   db_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [PER_W-1:0]  per_cnt;
    logic              press_q;
    logic              release_q;
    logic              step_q;
    logic              held;
    logic              accept;

    // The FSM state doubles as the debounced level the synchronised input is compared against.
    assign held   = (state == HELD);
    assign accept = (s[i] != held) && (db_cnt == DB_W'(DEBOUNCE_MS - 1));

    always_ff @(posedge clk_1khz or negedge switch_clr) begin
      if (!switch_clr) begin
        db_cnt <= '0;
      end else if ((s[i] == held) || accept) begin
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end

    // Hold counter saturates at the delay; after that the period counter paces repeat steps.
    always_ff @(posedge clk_1khz or negedge switch_clr) begin
      if (!switch_clr) begin
        state     <= IDLE;
        hold_cnt  <= '0;
        per_cnt   <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        step_q    <= 1'b0;
      end else begin
        press_q   <= 1'b0;
        release_q <= 1'b0;
        step_q    <= 1'b0;
        case (state)
          IDLE: begin
            if (accept) begin
              state    <= HELD;
              press_q  <= 1'b1;
              step_q   <= 1'b1;
              hold_cnt <= '0;
              per_cnt  <= '0;
            end
          end
          HELD: begin
            if (accept) begin
              state     <= IDLE;
              release_q <= 1'b1;
              hold_cnt  <= '0;
              per_cnt   <= '0;
            end else if (hold_cnt != HOLD_W'(REPEAT_DELAY_MS)) begin
              hold_cnt <= hold_cnt + 1'b1;
              if (hold_cnt == HOLD_W'(REPEAT_DELAY_MS - 1)) begin
                step_q  <= repeat_en[i];
                per_cnt <= '0;
              end
            end else if (per_cnt == PER_W'(REPEAT_PERIOD_MS - 1)) begin
              step_q  <= repeat_en[i];
              per_cnt <= '0;
            end else begin
              per_cnt <= per_cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end

    assign btn_level[i]   = held;
    assign btn_press[i]   = press_q;
    assign btn_release[i] = release_q;
    assign btn_step[i]    = step_q;
    assign btn_long[i]    = held && (hold_cnt == HOLD_W'(REPEAT_DELAY_MS));
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios with literal expectations plus
// a long random run compared every cycle against a timestamp-based model.
module tb_button_conditioner;

  localparam int         NB  = 3;
  localparam logic [2:0] INV = 3'b100;
  localparam int         DEB = 20;
  localparam int         DLY = 500;
  localparam int         PER = 200;

  logic          clk_1khz   = 1'b0;
  logic          switch_clr = 1'b1;
  logic [NB-1:0] btn_raw    = 3'b100;
  logic [NB-1:0] repeat_en  = 3'b001;
  logic [NB-1:0] btn_level, btn_press, btn_release, btn_step, btn_long;

  int total = 0;
  int bad   = 0;
  bit checking = 1'b0;

  always #5 clk_1khz = ~clk_1khz;

  button_conditioner #(
    .NUM_BTN(NB), .BTN_INVERT(INV), .DEBOUNCE_MS(DEB),
    .REPEAT_DELAY_MS(DLY), .REPEAT_PERIOD_MS(PER)
  ) dut (
    .clk_1khz(clk_1khz), .switch_clr(switch_clr), .btn_raw(btn_raw),
    .repeat_en(repeat_en), .btn_level(btn_level), .btn_press(btn_press),
    .btn_release(btn_release), .btn_step(btn_step), .btn_long(btn_long)
  );

  logic [NB-1:0] m_level = '0, m_press = '0, m_release = '0, m_step = '0, m_long = '0;
  logic [NB-1:0] hist[$];
  int            cyc = 0;
  bit            differing[NB];
  int            diff_start[NB];
  int            accept_at[NB];
  logic          m_s;
  int            m_off;
  bit            m_flip;

  // Model: a level flips once the synchronised input has disagreed with it for DEB
  // consecutive edges; repeat steps follow from the time elapsed since acceptance.
  always @(posedge clk_1khz or negedge switch_clr) begin
    if (!switch_clr) begin
      m_level = '0; m_press = '0; m_release = '0; m_step = '0; m_long = '0;
      hist.delete();
      for (int i = 0; i < NB; i++) differing[i] = 1'b0;
    end else begin
      cyc++;
      m_press = '0; m_release = '0; m_step = '0;
      for (int i = 0; i < NB; i++) begin
        m_s    = ((hist.size() >= 2) ? hist[hist.size()-2][i] : 1'b0) ^ INV[i];
        m_flip = 1'b0;
        if (m_s != m_level[i]) begin
          if (!differing[i]) begin
            differing[i]  = 1'b1;
            diff_start[i] = cyc;
          end
          if (cyc - diff_start[i] + 1 >= DEB) begin
            m_flip       = 1'b1;
            differing[i] = 1'b0;
          end
        end else begin
          differing[i] = 1'b0;
        end
        if (m_flip && !m_level[i]) begin
          m_level[i] = 1'b1; m_press[i] = 1'b1; m_step[i] = 1'b1; m_long[i] = 1'b0;
          accept_at[i] = cyc;
        end else if (m_flip) begin
          m_level[i] = 1'b0; m_release[i] = 1'b1; m_long[i] = 1'b0;
        end else if (m_level[i]) begin
          m_off     = cyc - accept_at[i];
          m_long[i] = (m_off >= DLY);
          if (repeat_en[i] && m_off >= DLY && ((m_off - DLY) % PER) == 0) m_step[i] = 1'b1;
        end
      end
      hist.push_back(btn_raw);
      if (hist.size() > 2) void'(hist.pop_front());
    end
  end

  task automatic check_output(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk_1khz) begin
    #3;
    if (checking) begin
      check_output("model_level",   int'(btn_level),   int'(m_level));
      check_output("model_press",   int'(btn_press),   int'(m_press));
      check_output("model_release", int'(btn_release), int'(m_release));
      check_output("model_step",    int'(btn_step),    int'(m_step));
      check_output("model_long",    int'(btn_long),    int'(m_long));
    end
  end

  task automatic apply_stimulus(input int ncyc);
    int hold_left[NB];
    int r;
    for (int i = 0; i < NB; i++) hold_left[i] = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk_1khz);
      for (int i = 0; i < NB; i++) begin
        if (hold_left[i] == 0) begin
          btn_raw[i] = ~btn_raw[i];
          r = int'($urandom_range(0, 7));
          if (r < 2)       hold_left[i] = int'($urandom_range(1, 8));
          else if (r == 2) hold_left[i] = int'($urandom_range(17, 23));
          else             hold_left[i] = int'($urandom_range(24, 1400));
        end else begin
          hold_left[i]--;
        end
        if ($urandom_range(0, 299) == 0) repeat_en[i] = ~repeat_en[i];
      end
      if ($urandom_range(0, 3999) == 0) begin
        @(posedge clk_1khz);
        #2 switch_clr = 1'b0;
        repeat (2) @(posedge clk_1khz);
        @(negedge clk_1khz);
        switch_clr = 1'b1;
      end
    end
  endtask

  int steps[$];
  int exp_steps[4] = '{0, 500, 900, 1100};
  int press_cnt;
  int press_at;

  initial begin
    #1 switch_clr = 1'b0;
    repeat (4) @(posedge clk_1khz);
    #1;
    check_output("reset_level", int'(btn_level), 0);
    check_output("reset_press", int'(btn_press), 0);
    check_output("reset_step",  int'(btn_step),  0);
    check_output("reset_long",  int'(btn_long),  0);
    checking = 1'b1;

    // Clean press on button 0 with auto-repeat and a gated window.
    @(negedge clk_1khz);
    switch_clr = 1'b1;
    btn_raw[0] = 1'b1;
    repeat (21) @(posedge clk_1khz);
    #1 check_output("press_e21_level", int'(btn_level[0]), 0);
    @(posedge clk_1khz);
    #1;
    check_output("press_e22_level", int'(btn_level[0]), 1);
    check_output("press_e22_press", int'(btn_press[0]), 1);
    check_output("press_e22_step",  int'(btn_step[0]),  1);
    @(posedge clk_1khz);
    #1;
    check_output("press_e23_press", int'(btn_press[0]), 0);
    check_output("press_e23_step",  int'(btn_step[0]),  0);
    steps.delete();
    steps.push_back(0);
    for (int off = 2; off <= 1200; off++) begin
      @(negedge clk_1khz);
      repeat_en[0] = !(off >= 600 && off <= 800);
      @(posedge clk_1khz);
      #1;
      if (btn_step[0]) steps.push_back(off);
      if (off == 499) check_output("long_off499", int'(btn_long[0]), 0);
      if (off == 500) check_output("long_off500", int'(btn_long[0]), 1);
      if (off == 700) check_output("long_off700", int'(btn_long[0]), 1);
    end
    check_output("step_count", steps.size(), 4);
    for (int k = 0; k < 4; k++)
      if (k < steps.size()) check_output("step_offset", steps[k], exp_steps[k]);

    @(negedge clk_1khz);
    btn_raw[0] = 1'b0;
    repeat (21) @(posedge clk_1khz);
    #1;
    check_output("rel_e21_release", int'(btn_release[0]), 0);
    check_output("rel_e21_long",    int'(btn_long[0]),    1);
    @(posedge clk_1khz);
    #1;
    check_output("rel_e22_release", int'(btn_release[0]), 1);
    check_output("rel_e22_level",   int'(btn_level[0]),   0);
    check_output("rel_e22_long",    int'(btn_long[0]),    0);
    check_output("rel_e22_step",    int'(btn_step[0]),    0);
    @(posedge clk_1khz);
    #1 check_output("rel_e23_release", int'(btn_release[0]), 0);

    // Bouncing button 1 must yield a single press after the last rising edge.
    press_cnt = 0;
    press_at  = -1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk_1khz);
      btn_raw[1] = (c >= 60) ? 1'b1 : (((c / 5) % 2) == 0);
      @(posedge clk_1khz);
      #1;
      if (btn_press[1]) begin
        press_cnt++;
        press_at = c;
      end
    end
    check_output("bounce_press_count", press_cnt, 1);
    check_output("bounce_press_cycle", press_at, 81);
    @(negedge clk_1khz);
    btn_raw[1] = 1'b0;
    repeat (30) @(posedge clk_1khz);

    // Active-low button 2.
    @(negedge clk_1khz);
    btn_raw[2] = 1'b0;
    repeat (21) @(posedge clk_1khz);
    #1 check_output("inv_e21_level", int'(btn_level[2]), 0);
    @(posedge clk_1khz);
    #1;
    check_output("inv_e22_press", int'(btn_press[2]), 1);
    check_output("inv_e22_level", int'(btn_level[2]), 1);
    @(negedge clk_1khz);
    btn_raw[2] = 1'b1;
    repeat (30) @(posedge clk_1khz);

    // Reset in the middle of a long hold.
    @(negedge clk_1khz);
    btn_raw[0] = 1'b1;
    repeat (22) @(posedge clk_1khz);
    #1 check_output("rst_hold_press", int'(btn_press[0]), 1);
    repeat (600) @(posedge clk_1khz);
    #1 check_output("rst_hold_long", int'(btn_long[0]), 1);
    #1 switch_clr = 1'b0;
    #1;
    check_output("rst_mid_level",   int'(btn_level),   0);
    check_output("rst_mid_press",   int'(btn_press),   0);
    check_output("rst_mid_release", int'(btn_release), 0);
    check_output("rst_mid_step",    int'(btn_step),    0);
    check_output("rst_mid_long",    int'(btn_long),    0);
    repeat (3) @(posedge clk_1khz);
    @(negedge clk_1khz);
    switch_clr = 1'b1;
    repeat (21) @(posedge clk_1khz);
    #1 check_output("rst_again_e21_press", int'(btn_press[0]), 0);
    @(posedge clk_1khz);
    #1 check_output("rst_again_e22_press", int'(btn_press[0]), 1);
    @(negedge clk_1khz);
    btn_raw[0] = 1'b0;
    repeat (40) @(posedge clk_1khz);

    apply_stimulus(20000);
    repeat (5) @(posedge clk_1khz);
    #4;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
